// File: rtl/rs_pkg.sv
// Shared definitions for the simple-FU reservation station.
// Holds the entry field layout, the entry/tag widths and the wake-up
// function used both on stored slots and on the dispatch bypass path.
package rs_pkg;

  localparam int ENTRY_W = 114;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;

  // Entry layout: {ctrl, regwrite, s2, s2_valid, s1, s1_valid, rd}
  localparam int RD_LSB       = 0;
  localparam int S1_VALID_BIT = 5;
  localparam int S1_LSB       = 6;
  localparam int S2_VALID_BIT = 38;
  localparam int S2_LSB       = 39;
  localparam int REGWRITE_BIT = 71;
  localparam int CTRL_LSB     = 72;
  localparam int ALUOP_LSB    = 76;
  localparam int ALUOP_MSB    = 81;

  // Capture broadcast results into any source still waiting on a tag.
  // cdb0 is checked first so it wins when both buses carry the same tag.
  // A source that is already valid holds a value, not a tag, and is left alone.
  function automatic logic [ENTRY_W-1:0] wakeup(
    input logic [ENTRY_W-1:0] entry,
    input logic               c0_valid,
    input logic [TAG_W-1:0]   c0_tag,
    input logic [DATA_W-1:0]  c0_data,
    input logic               c1_valid,
    input logic [TAG_W-1:0]   c1_tag,
    input logic [DATA_W-1:0]  c1_data
  );
    logic [ENTRY_W-1:0] res;
    res = entry;
    if (!entry[S1_VALID_BIT]) begin
      if (c0_valid && (c0_tag == entry[S1_LSB +: TAG_W])) begin
        res[S1_LSB +: DATA_W] = c0_data;
        res[S1_VALID_BIT]     = 1'b1;
      end else if (c1_valid && (c1_tag == entry[S1_LSB +: TAG_W])) begin
        res[S1_LSB +: DATA_W] = c1_data;
        res[S1_VALID_BIT]     = 1'b1;
      end
    end
    if (!entry[S2_VALID_BIT]) begin
      if (c0_valid && (c0_tag == entry[S2_LSB +: TAG_W])) begin
        res[S2_LSB +: DATA_W] = c0_data;
        res[S2_VALID_BIT]     = 1'b1;
      end else if (c1_valid && (c1_tag == entry[S2_LSB +: TAG_W])) begin
        res[S2_LSB +: DATA_W] = c1_data;
        res[S2_VALID_BIT]     = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_slot.sv
// One reservation-station slot.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   invalidate the slot (highest priority)
//   alloc                   load alloc_entry / alloc_rob_num (only asserted when empty)
//   issue                   execute stage consumed this slot
//   cdbN_valid/rob_num/data result broadcast buses for wake-up
//   valid                   slot holds an instruction
//   entry, rob_num          slot contents, forced to zero when empty
module rs_slot
  import rs_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               alloc,
  input  logic [ENTRY_W-1:0] alloc_entry,
  input  logic [TAG_W-1:0]   alloc_rob_num,
  input  logic               issue,
  input  logic               cdb0_valid,
  input  logic [TAG_W-1:0]   cdb0_rob_num,
  input  logic [DATA_W-1:0]  cdb0_data,
  input  logic               cdb1_valid,
  input  logic [TAG_W-1:0]   cdb1_rob_num,
  input  logic [DATA_W-1:0]  cdb1_data,
  output logic               valid,
  output logic [ENTRY_W-1:0] entry,
  output logic [TAG_W-1:0]   rob_num
);

  logic               vld_q;
  logic [ENTRY_W-1:0] data_q;
  logic [TAG_W-1:0]   tag_q;

  // Priority: flush > issue (on a valid slot) > alloc > wake-up.
  // Issue beats a same-cycle wake-up so a consumed slot never lingers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (issue && vld_q) begin
      vld_q <= 1'b0;
    end else if (alloc && !vld_q) begin
      vld_q  <= 1'b1;
      data_q <= alloc_entry;
      tag_q  <= alloc_rob_num;
    end else if (vld_q) begin
      data_q <= wakeup(data_q, cdb0_valid, cdb0_rob_num, cdb0_data,
                       cdb1_valid, cdb1_rob_num, cdb1_data);
    end
  end

  // Empty slots read as zero so both source-valid bits look clear downstream.
  assign valid   = vld_q;
  assign entry   = vld_q ? data_q : '0;
  assign rob_num = vld_q ? tag_q  : '0;

endmodule

// File: rtl/rs_simple.sv
// Two-entry reservation station for the simple functional unit.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       invalidate both slots, selector back to 0
//   dispatch_valid/entry/rob_num  incoming instruction
//   dispatch_ready              at least one slot free (registered state only)
//   cdbN_valid/rob_num/data     result broadcast buses
//   rs_simple_N, rs_simple_N_entry_num  slot contents to the execute stage
//   selector                    index of the most recently allocated slot
//   simple_N_issue              execute stage consumed slot N
module rs_simple #(
  parameter int ENTRY_W = rs_pkg::ENTRY_W,
  parameter int TAG_W   = rs_pkg::TAG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               dispatch_valid,
  input  logic [ENTRY_W-1:0] dispatch_entry,
  input  logic [TAG_W-1:0]   dispatch_rob_num,
  output logic               dispatch_ready,
  input  logic               cdb0_valid,
  input  logic [TAG_W-1:0]   cdb0_rob_num,
  input  logic [31:0]        cdb0_data,
  input  logic               cdb1_valid,
  input  logic [TAG_W-1:0]   cdb1_rob_num,
  input  logic [31:0]        cdb1_data,
  output logic [ENTRY_W-1:0] rs_simple_0,
  output logic [ENTRY_W-1:0] rs_simple_1,
  output logic [TAG_W-1:0]   rs_simple_0_entry_num,
  output logic [TAG_W-1:0]   rs_simple_1_entry_num,
  output logic               selector,
  input  logic               simple_0_issue,
  input  logic               simple_1_issue
);
  import rs_pkg::*;

  logic               valid0, valid1;
  logic               do_alloc;
  logic               alloc0, alloc1;
  logic [ENTRY_W-1:0] bypass_entry;

  // Readiness comes from the registered valids only; a slot freed by issue
  // this cycle is not offered until the next one.
  assign dispatch_ready = ~(valid0 & valid1);
  assign do_alloc       = dispatch_valid & dispatch_ready & ~flush;
  assign alloc0         = do_alloc & ~valid0;
  assign alloc1         = do_alloc &  valid0;

  // Apply same-cycle broadcasts to the incoming entry so they are not lost.
  assign bypass_entry = wakeup(dispatch_entry, cdb0_valid, cdb0_rob_num, cdb0_data,
                               cdb1_valid, cdb1_rob_num, cdb1_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selector <= 1'b0;
    end else if (flush) begin
      selector <= 1'b0;
    end else if (do_alloc) begin
      selector <= valid0;
    end
  end

  rs_slot u_slot0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .alloc         (alloc0),
    .alloc_entry   (bypass_entry),
    .alloc_rob_num (dispatch_rob_num),
    .issue         (simple_0_issue),
    .cdb0_valid    (cdb0_valid),
    .cdb0_rob_num  (cdb0_rob_num),
    .cdb0_data     (cdb0_data),
    .cdb1_valid    (cdb1_valid),
    .cdb1_rob_num  (cdb1_rob_num),
    .cdb1_data     (cdb1_data),
    .valid         (valid0),
    .entry         (rs_simple_0),
    .rob_num       (rs_simple_0_entry_num)
  );

  rs_slot u_slot1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .alloc         (alloc1),
    .alloc_entry   (bypass_entry),
    .alloc_rob_num (dispatch_rob_num),
    .issue         (simple_1_issue),
    .cdb0_valid    (cdb0_valid),
    .cdb0_rob_num  (cdb0_rob_num),
    .cdb0_data     (cdb0_data),
    .cdb1_valid    (cdb1_valid),
    .cdb1_rob_num  (cdb1_rob_num),
    .cdb1_data     (cdb1_data),
    .valid         (valid1),
    .entry         (rs_simple_1),
    .rob_num       (rs_simple_1_entry_num)
  );

endmodule

// File: doc/rs_simple.md
Name: rs_simple

Overview:
- Two-entry reservation station feeding the "simple" functional unit.
- Accepts one dispatched instruction per cycle from the dispatch stage and holds it until both operands are available.
- Captures missing operands from the result broadcast buses (wake-up).
- Presents both slots to the simple-FU execute stage and frees a slot when that stage asserts its issue strobe.

Parameters:
- ENTRY_W, 114: width of one RS entry.
- TAG_W, 4: ROB entry-number width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous; invalidates both slots
- dispatch_valid  input  1  dispatch request this cycle
- dispatch_entry  input  114  {ctrl[113:72], regwrite[71], s2[70:39], s2_valid[38], s1[37:6], s1_valid[5], rd[4:0]}; aluop at [81:76]; when sX_valid=0, sX[3:0] holds the producer ROB tag
- dispatch_rob_num  input  4  ROB entry number of the dispatched instruction
- dispatch_ready  output  1  at least one slot free
- cdb0_valid, cdb1_valid  input  1 each  result broadcast valid
- cdb0_rob_num, cdb1_rob_num  input  4 each  tag of the broadcast result
- cdb0_data, cdb1_data  input  32 each  broadcast result value
- rs_simple_0, rs_simple_1  output  114 each  slot contents to execute stage
- rs_simple_0_entry_num, rs_simple_1_entry_num  output  4 each  ROB number per slot
- selector  output  1  index of the more recently allocated slot
- simple_0_issue, simple_1_issue  input  1 each  execute stage consumed the slot this cycle

Behaviour:
- Reset (async, rst_n=0): both slot valid bits 0; every stored field 0; selector=0. All outputs are 0 except dispatch_ready=1.
- Empty slot: rs_simple_X is driven all-zero, so s1_valid=s2_valid=0 and the execute stage never sees it as ready. entry_num reads 0.
- dispatch_ready = ~(slot0_valid & slot1_valid), computed from registered state only. It does not look at same-cycle issue.
- Allocation occurs at the clock edge when dispatch_valid & dispatch_ready.
  - Target slot is the lowest-index slot that is free at the start of the cycle.
  - selector <= target index.
  - dispatch_valid while dispatch_ready=0 is ignored: no state change, and the request is not queued.
- Freeing: at the clock edge, simple_X_issue=1 on a valid slot clears slot X. Issue on an empty slot is ignored.
- A slot freed by issue cannot be re-allocated in the same cycle; it becomes available the following cycle.
- Wake-up, per stored valid slot and per source with sX_valid=0:
  - If cdbN_valid and cdbN_rob_num == sX[3:0], then sX <= cdbN_data and sX_valid <= 1 at the edge.
  - If both CDBs match, cdb0 has priority.
  - An operand that is already valid is never overwritten.
- Dispatch bypass: wake-up is also applied to dispatch_entry in its allocation cycle, so a result broadcast in the same cycle is not lost.
- Wake-up and issue on the same slot in the same cycle: issue wins and the slot is cleared.
- Latency:
  - An instruction dispatched with both operands valid appears as ready on rs_simple_X in the cycle after dispatch.
  - Wake-up becomes visible one cycle after the broadcast.
- flush: clears both valid bits and sets selector=0 at the edge. It overrides dispatch, wake-up and issue in that cycle.
- Reset mid-operation: all state is discarded immediately. No partial entry survives.
- Fields other than sources and valid bits are stored verbatim and never modified.

Decomposition:
- Shared package rs_pkg holds:
  - field offset constants: RD_LSB, S1_VALID_BIT, S1_LSB, S2_VALID_BIT, S2_LSB, REGWRITE_BIT, ALUOP_LSB/MSB;
  - ENTRY_W and TAG_W;
  - a wake-up function: (entry, cdb valid/tag/data ×2) -> updated entry.
- Sub-module rs_slot: one slot register with alloc, issue, flush and wake-up handling. It is instantiated twice.
- The top level holds the allocation priority, selector, dispatch_ready and the bypass logic.

Test Plan:
- Reset, then dispatch entry E1 (s1_valid=1, s1=0x5, s2_valid=1, s2=0x3, rob_num=2): next cycle rs_simple_0=E1, rs_simple_0_entry_num=2, selector=0, dispatch_ready=1.
- Fill both slots (rob 2, then 3), then dispatch a third instruction: dispatch_ready=0 and the third is dropped. Then assert simple_0_issue: slot0 is empty next cycle and dispatch_ready=1.
- Slot with s2_valid=0, s2[3:0]=7; cdb1_valid with rob_num=7, data=0xDEADBEEF: next cycle s2=0xDEADBEEF, s2_valid=1.
- Both CDBs broadcast tag 7 (cdb0 data=0x11, cdb1 data=0x22): captured value is 0x11.
- Dispatch an entry with s1 tag 4 while cdb0 broadcasts rob 4, data=0xA5: the stored entry already has s1=0xA5, s1_valid=1.
- Both slots valid, assert flush together with dispatch_valid and issue: next cycle both slots are empty, selector=0, dispatch_ready=1. Async rst_n low mid-cycle clears the outputs immediately.
